// File: rtl/accum_pkg.sv
// Shared defaults and packet typedefs for the accumulate-buffer bank arbiter.
package accum_pkg;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_NUM_BANK = 4;
  localparam int DEF_ADDR_W   = 10;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_LOC_W    = DEF_ADDR_W - $clog2(DEF_NUM_BANK);

  typedef struct packed {
    logic                  valid;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } req_pkt_t;

  typedef struct packed {
    logic                  en;
    logic [DEF_LOC_W-1:0]  addr;
    logic [DEF_DATA_W-1:0] data;
  } bank_pkt_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for one bank: one-hot grant, pointer moves past the winner.
module rr_arbiter
  import accum_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic             w_found;
  int               w_idx;

  // Search from the pointer upward, wrapping, for the first active requester
  always_comb begin
    grant     = '0;
    w_found   = 1'b0;
    w_ptr_nxt = r_ptr;
    w_idx     = 0;
    if (!reset) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_idx = (int'(r_ptr) + k) % NUM_REQ;
        if (!w_found && req[w_idx]) begin
          grant[w_idx] = 1'b1;
          w_found      = 1'b1;
          w_ptr_nxt    = PTR_W'((w_idx + 1) % NUM_REQ);
        end else begin
          w_found = w_found;
        end
      end
    end else begin
      grant = '0;
    end
  end

  // Pointer register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule

// File: rtl/accum_bank_arbiter.sv
// Crossbar-to-bank accumulate arbiter: per-bank round-robin, 2-stage read-modify-write
// with write-to-read forwarding. Define ACCUM_SAT_EN for saturating accumulation.
module accum_bank_arbiter
  import accum_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int NUM_BANK = DEF_NUM_BANK,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W
) (
  input  logic                                           clock,
  input  logic                                           reset,
  input  logic [NUM_REQ-1:0]                             req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]                      req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]                      req_data,
  output logic [NUM_REQ-1:0]                             req_ready,
  output logic [NUM_BANK-1:0]                            bank_rd_en,
  output logic [NUM_BANK*(ADDR_W-$clog2(NUM_BANK))-1:0]  bank_rd_addr,
  input  logic [NUM_BANK*DATA_W-1:0]                     bank_rd_data,
  output logic [NUM_BANK-1:0]                            bank_wr_en,
  output logic [NUM_BANK*(ADDR_W-$clog2(NUM_BANK))-1:0]  bank_wr_addr,
  output logic [NUM_BANK*DATA_W-1:0]                     bank_wr_data,
  output logic                                           idle
);

  localparam int BANK_W = $clog2(NUM_BANK);
  localparam int LOC_W  = ADDR_W - BANK_W;

  function automatic logic [DATA_W-1:0] accum_add(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
`ifdef ACCUM_SAT_EN
    if (s[DATA_W] != s[DATA_W-1]) begin
      return s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      return s[DATA_W-1:0];
    end
`else
    return s[DATA_W-1:0];
`endif
  endfunction

  logic [NUM_REQ-1:0]  w_bank_req [NUM_BANK];
  logic [NUM_REQ-1:0]  w_grant    [NUM_BANK];
  logic [NUM_BANK-1:0] w_rd_en;
  logic [NUM_BANK-1:0] w_wr_en;
  logic [LOC_W-1:0]    w_s1_addr  [NUM_BANK];
  logic [DATA_W-1:0]   w_s1_data  [NUM_BANK];
  logic [DATA_W-1:0]   w_operand  [NUM_BANK];
  logic [DATA_W-1:0]   w_wr_data  [NUM_BANK];

  logic [NUM_BANK-1:0] r_s2_valid;
  logic [LOC_W-1:0]    r_s2_addr  [NUM_BANK];
  logic [DATA_W-1:0]   r_s2_data  [NUM_BANK];
  logic [NUM_BANK-1:0] r_fwd_valid;
  logic [LOC_W-1:0]    r_fwd_addr [NUM_BANK];
  logic [DATA_W-1:0]   r_fwd_data [NUM_BANK];

  // Route each valid lane to the bank selected by its low address bits
  always_comb begin
    for (int b = 0; b < NUM_BANK; b++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        w_bank_req[b][i] = req_valid[i] &&
          ((req_addr[i*ADDR_W +: ADDR_W] % ADDR_W'(NUM_BANK)) == ADDR_W'(b));
      end
    end
  end

  for (genvar gb = 0; gb < NUM_BANK; gb++) begin : g_arb
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
      .clock (clock),
      .reset (reset),
      .req   (w_bank_req[gb]),
      .grant (w_grant[gb])
    );
  end

  // Stage 1: one-hot AND-OR mux of the winning lane into each bank's read port
  always_comb begin
    req_ready    = '0;
    bank_rd_addr = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      w_rd_en[b]   = |w_grant[b];
      w_s1_addr[b] = '0;
      w_s1_data[b] = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        w_s1_addr[b] = w_s1_addr[b] |
          ({LOC_W{w_grant[b][i]}} & LOC_W'(req_addr[i*ADDR_W +: ADDR_W] >> BANK_W));
        w_s1_data[b] = w_s1_data[b] |
          ({DATA_W{w_grant[b][i]}} & req_data[i*DATA_W +: DATA_W]);
        req_ready[i] = req_ready[i] | w_grant[b][i];
      end
      bank_rd_addr[b*LOC_W +: LOC_W] = w_s1_addr[b];
    end
    bank_rd_en = w_rd_en;
  end

  // Stage-2 pipeline and last-write capture for forwarding
  always_ff @(posedge clock) begin
    for (int b = 0; b < NUM_BANK; b++) begin
      if (reset) begin
        r_s2_valid[b]  <= 1'b0;
        r_fwd_valid[b] <= 1'b0;
      end else begin
        r_s2_valid[b]  <= w_rd_en[b];
        r_fwd_valid[b] <= w_wr_en[b];
      end
      if (w_rd_en[b]) begin
        r_s2_addr[b] <= w_s1_addr[b];
        r_s2_data[b] <= w_s1_data[b];
      end else begin
        r_s2_addr[b] <= r_s2_addr[b];
        r_s2_data[b] <= r_s2_data[b];
      end
      r_fwd_addr[b] <= r_s2_addr[b];
      r_fwd_data[b] <= w_wr_data[b];
    end
  end

  // Stage 2: the bank returns stale data when last cycle's write hit the same address
  always_comb begin
    bank_wr_addr = '0;
    bank_wr_data = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      w_wr_en[b] = r_s2_valid[b] & ~reset;
      if (r_fwd_valid[b] && (r_fwd_addr[b] == r_s2_addr[b])) begin
        w_operand[b] = r_fwd_data[b];
      end else begin
        w_operand[b] = bank_rd_data[b*DATA_W +: DATA_W];
      end
      w_wr_data[b] = accum_add(w_operand[b], r_s2_data[b]);
      bank_wr_addr[b*LOC_W +: LOC_W]   = r_s2_addr[b];
      bank_wr_data[b*DATA_W +: DATA_W] = w_wr_data[b];
    end
    bank_wr_en = w_wr_en;
  end

  assign idle = reset | (~|req_valid & ~|r_s2_valid);

endmodule

// File: tb/tb_accum_bank_arbiter.sv
// Self-checking bench for accum_bank_arbiter with a behavioural single-ported bank model.
module tb_accum_bank_arbiter;
  import accum_pkg::*;

  localparam int NR = 4;
  localparam int NB = 4;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int LW = 8;

  logic             clock;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic [NB-1:0]    bank_rd_en;
  logic [NB*LW-1:0] bank_rd_addr;
  logic [NB*DW-1:0] bank_rd_data;
  logic [NB-1:0]    bank_wr_en;
  logic [NB*LW-1:0] bank_wr_addr;
  logic [NB*DW-1:0] bank_wr_data;
  logic             idle;

  accum_bank_arbiter dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .bank_rd_en   (bank_rd_en),
    .bank_rd_addr (bank_rd_addr),
    .bank_rd_data (bank_rd_data),
    .bank_wr_en   (bank_wr_en),
    .bank_wr_addr (bank_wr_addr),
    .bank_wr_data (bank_wr_data),
    .idle         (idle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Bank model: registered read returning old data on a same-cycle write, plus a preload port
  logic [DW-1:0] mem [NB][256];
  logic [DW-1:0] rd_q [NB];
  logic          pre_en;
  logic [1:0]    pre_b;
  logic [LW-1:0] pre_a;
  logic [DW-1:0] pre_d;

  always @(posedge clock) begin
    for (int b = 0; b < NB; b++) begin
      if (bank_rd_en[b]) rd_q[b] <= mem[b][bank_rd_addr[b*LW +: LW]];
      if (bank_wr_en[b]) mem[b][bank_wr_addr[b*LW +: LW]] <= bank_wr_data[b*DW +: DW];
    end
    if (pre_en) mem[pre_b][pre_a] <= pre_d;
  end
  assign bank_rd_data = {rd_q[3], rd_q[2], rd_q[1], rd_q[0]};

  int checks;
  int failures;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] val);
    @(negedge clock);
    pre_en = 1'b1;
    pre_b  = addr[1:0];
    pre_a  = addr[9:2];
    pre_d  = val;
    @(negedge clock);
    pre_en = 1'b0;
  endtask

  task automatic set_lane(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_addr[i*AW +: AW]  = a;
    req_data[i*DW +: DW]  = d;
  endtask

  task automatic reset_pulse();
    @(negedge clock);
    req_valid = '0;
    reset     = 1'b1;
    @(negedge clock);
    reset     = 1'b0;
  endtask

  typedef struct packed {
    req_pkt_t [3:0]         lanes;
    logic [3:0][DW-1:0]     pre;
    logic [3:0]             exp_ready;
    logic [3:0]             exp_wr_en;
    logic [3:0][LW-1:0]     exp_wr_addr;
    logic [3:0][DW-1:0]     exp_wr_data;
  } vec_t;

  localparam int NV = 5;
  vec_t vecs [NV];

  task automatic run_vec(input int k, input vec_t v);
    for (int i = 0; i < NR; i++)
      if (v.lanes[i].valid) preload(v.lanes[i].addr, v.pre[i]);
    @(negedge clock);
    for (int i = 0; i < NR; i++) set_lane(i, v.lanes[i].valid, v.lanes[i].addr, v.lanes[i].data);
    #1;
    chk($sformatf("v%0d_ready", k), 32'(req_ready), 32'(v.exp_ready));
    chk($sformatf("v%0d_rd_en", k), 32'(bank_rd_en), 32'(v.exp_wr_en));
    for (int b = 0; b < NB; b++)
      if (v.exp_wr_en[b])
        chk($sformatf("v%0d_rd_addr%0d", k, b), 32'(bank_rd_addr[b*LW +: LW]), 32'(v.exp_wr_addr[b]));
    @(negedge clock);
    req_valid = '0;
    #1;
    chk($sformatf("v%0d_wr_en", k), 32'(bank_wr_en), 32'(v.exp_wr_en));
    chk($sformatf("v%0d_idle_busy", k), 32'(idle), 32'(v.exp_wr_en == 4'b0000));
    for (int b = 0; b < NB; b++) begin
      if (v.exp_wr_en[b]) begin
        chk($sformatf("v%0d_wr_addr%0d", k, b), 32'(bank_wr_addr[b*LW +: LW]), 32'(v.exp_wr_addr[b]));
        chk($sformatf("v%0d_wr_data%0d", k, b), 32'(bank_wr_data[b*DW +: DW]), 32'(v.exp_wr_data[b]));
      end
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    pre_en    = 1'b0;
    pre_b     = '0;
    pre_a     = '0;
    pre_d     = '0;
    req_addr  = '0;
    req_data  = '0;

    for (int k = 0; k < NV; k++) vecs[k] = '0;
    // Single read-modify-write: bank1 addr1 holds 10, add 3
    vecs[0].lanes[0] = {1'b1, 10'd5, 16'd3};
    vecs[0].pre[0] = 16'd10;
    vecs[0].exp_ready = 4'b0001; vecs[0].exp_wr_en = 4'b0010;
    vecs[0].exp_wr_addr[1] = 8'd1; vecs[0].exp_wr_data[1] = 16'd13;
    // Four lanes to four banks in one cycle
    for (int i = 0; i < 4; i++) begin
      vecs[1].lanes[i] = {1'b1, 10'(i), 16'd7};
      vecs[1].pre[i] = 16'd0;
      vecs[1].exp_wr_addr[i] = 8'd0;
      vecs[1].exp_wr_data[i] = 16'd7;
    end
    vecs[1].exp_ready = 4'b1111; vecs[1].exp_wr_en = 4'b1111;
    // Signed operands in two banks: 3 + -5 = -2, -50 + 100 = 50
    vecs[2].lanes[1] = {1'b1, 10'd9, 16'hFFFB};
    vecs[2].pre[1] = 16'd3;
    vecs[2].lanes[3] = {1'b1, 10'd14, 16'd100};
    vecs[2].pre[3] = 16'hFFCE;
    vecs[2].exp_ready = 4'b1010; vecs[2].exp_wr_en = 4'b0110;
    vecs[2].exp_wr_addr[1] = 8'd2; vecs[2].exp_wr_data[1] = 16'hFFFE;
    vecs[2].exp_wr_addr[2] = 8'd3; vecs[2].exp_wr_data[2] = 16'd50;
    // Positive overflow: 32767 + 5; negative overflow: -1 + -32768
    vecs[3].lanes[2] = {1'b1, 10'd11, 16'd5};
    vecs[3].pre[2] = 16'h7FFF;
    vecs[3].exp_ready = 4'b0100; vecs[3].exp_wr_en = 4'b1000;
    vecs[3].exp_wr_addr[3] = 8'd2;
    vecs[4].lanes[0] = {1'b1, 10'd12, 16'h8000};
    vecs[4].pre[0] = 16'hFFFF;
    vecs[4].exp_ready = 4'b0001; vecs[4].exp_wr_en = 4'b0001;
    vecs[4].exp_wr_addr[0] = 8'd3;
`ifdef ACCUM_SAT_EN
    vecs[3].exp_wr_data[3] = 16'h7FFF;
    vecs[4].exp_wr_data[0] = 16'h8000;
`else
    vecs[3].exp_wr_data[3] = 16'h8004;
    vecs[4].exp_wr_data[0] = 16'h7FFF;
`endif

    // Reset state with all lanes requesting
    reset     = 1'b1;
    req_valid = 4'b1111;
    @(negedge clock);
    @(negedge clock);
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_rd_en", 32'(bank_rd_en), 32'h0);
    chk("rst_wr_en", 32'(bank_wr_en), 32'h0);
    chk("rst_idle", 32'(idle), 32'h1);
    req_valid = '0;
    reset     = 1'b0;

    for (int k = 0; k < NV; k++) run_vec(k, vecs[k]);

    // Four lanes hammer one address: grants 0..3 back to back, forwarding builds 1,2,3,4
    reset_pulse();
    preload(10'd4, 16'd0);
    @(negedge clock);
    for (int i = 0; i < NR; i++) set_lane(i, 1'b1, 10'd4, 16'd1);
    for (int k = 0; k < NR; k++) begin
      #1;
      chk($sformatf("s1_ready_c%0d", k), 32'(req_ready), 32'(1 << k));
      if (k > 0) chk($sformatf("s1_wr_data_c%0d", k), 32'(bank_wr_data[15:0]), 32'(k));
      @(negedge clock);
      req_valid[k] = 1'b0;
    end
    #1;
    chk("s1_wr_en_last", 32'(bank_wr_en), 32'h1);
    chk("s1_wr_data_last", 32'(bank_wr_data[15:0]), 32'd4);
    @(negedge clock);
    #1;
    chk("s1_idle", 32'(idle), 32'h1);
    chk("s1_mem", 32'(mem[0][1]), 32'd4);

    // Lanes 1 and 3 both held on bank2: must alternate
    reset_pulse();
    @(negedge clock);
    set_lane(1, 1'b1, 10'd2, 16'd1);
    set_lane(3, 1'b1, 10'd6, 16'd1);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("s2_ready_c%0d", k), 32'(req_ready), (k % 2 == 0) ? 32'h2 : 32'h8);
      @(negedge clock);
    end
    req_valid = '0;

    // Reset right after a grant drops the pending write and clears the pointer
    reset_pulse();
    preload(10'd5, 16'd50);
    @(negedge clock);
    set_lane(0, 1'b1, 10'd5, 16'd3);
    #1;
    chk("s3_ready", 32'(req_ready), 32'h1);
    @(negedge clock);
    reset = 1'b1;
    set_lane(0, 1'b1, 10'd5, 16'd3);
    set_lane(1, 1'b1, 10'd5, 16'd4);
    #1;
    chk("s3_rst_wr_en", 32'(bank_wr_en), 32'h0);
    chk("s3_rst_ready", 32'(req_ready), 32'h0);
    chk("s3_rst_idle", 32'(idle), 32'h1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("s3_ptr0_ready", 32'(req_ready), 32'h1);
    @(negedge clock);
    req_valid = '0;
    #1;
    chk("s3_wr_data", 32'(bank_wr_data[31:16]), 32'd53);
    @(negedge clock);
    #1;
    chk("s3_idle", 32'(idle), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/accum_bank_arbiter.md
ACCUM_BANK_ARBITER -- requirements
Module: accum_bank_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, the number of crossbar output lanes (requesters).
REQ-002 The block SHALL have parameter NUM_BANK, default 4 (power of 2), the number of single-ported accumulate-buffer banks.
REQ-003 The block SHALL have parameter ADDR_W, default 10, the global accumulate address width.
REQ-004 The block SHALL have parameter DATA_W, default 16, the signed partial-sum width.
REQ-005 The block SHALL have these ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  lane holds a partial sum.
- req_addr  in  NUM_REQ x ADDR_W  global accumulate address.
- req_data  in  NUM_REQ x DATA_W  signed partial sum.
- req_ready  out  NUM_REQ  lane granted this cycle.
- bank_rd_en  out  NUM_BANK  bank read strobe.
- bank_rd_addr  out  NUM_BANK x (ADDR_W-log2 NUM_BANK)  bank-local read address.
- bank_rd_data  in  NUM_BANK x DATA_W  read data, valid 1 cycle after bank_rd_en.
- bank_wr_en  out  NUM_BANK  bank write strobe.
- bank_wr_addr  out  NUM_BANK x (ADDR_W-log2 NUM_BANK)  bank-local write address.
- bank_wr_data  out  NUM_BANK x DATA_W  accumulated value.
- idle  out  1  no pending request and no operation in flight.

Function
REQ-006 Bank select SHALL be req_addr mod NUM_BANK; bank-local address SHALL be req_addr >> log2(NUM_BANK).
REQ-007 Each bank SHALL grant at most one requester per cycle, using round-robin among lanes with req_valid targeting that bank.
REQ-008 req_ready[i] SHALL be combinational and high only in the cycle lane i is granted; the transfer occurs when req_valid and req_ready are both high.
REQ-009 A non-granted lane SHALL hold its request; it SHALL be granted within NUM_REQ cycles of contention.
REQ-010 The round-robin pointer of a bank SHALL move to (granted lane + 1) mod NUM_REQ after a grant and SHALL hold when there is no grant.
REQ-011 Each grant SHALL be a 2-stage read-modify-write.
- Cycle t: bank_rd_en=1, bank_rd_addr=local address; addr and data are registered.
- Cycle t+1: bank_wr_en=1, bank_wr_addr=same address, bank_wr_data=operand+req_data.
REQ-012 The operand SHALL come from forwarding when the previous cycle's write in that bank went to the same address (the bank returns old data on a same-cycle read/write); it SHALL be bank_rd_data otherwise.
REQ-013 Back-to-back grants to one address SHALL accumulate correctly at one grant per cycle with no stall.
REQ-014 Different banks SHALL operate fully in parallel; throughput is up to NUM_BANK sums per cycle.
REQ-015 idle SHALL equal ~|req_valid & no stage-2 valid in any bank.

Reset
REQ-016 During reset, req_ready, bank_rd_en and bank_wr_en SHALL be 0, and all stage-2 valids and forwarding valids SHALL be cleared.
REQ-017 During reset, round-robin pointers SHALL be 0 and idle SHALL be 1 (req_valid is ignored).
REQ-018 An in-flight stage-2 write SHALL be dropped by reset; the write-enable is never issued.

Configuration
REQ-019 With ACCUM_SAT_EN defined, the addition SHALL saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-020 Without ACCUM_SAT_EN, the addition SHALL wrap modulo 2^DATA_W.

Structure
REQ-021 NUM_REQ, NUM_BANK, ADDR_W, DATA_W defaults and the request/bank-port packet typedefs SHALL live in the shared package accum_pkg.
REQ-022 Per-bank arbitration SHALL be a sub-module rr_arbiter (NUM_REQ request in, one-hot grant out, pointer state inside), instantiated NUM_BANK times.

Verification
REQ-023 Lane0 addr=5, data=3, with bank1 addr1 holding 10 -> req_ready[0]=1 at t; bank_wr_en[1]=1 with addr 1 and data 13 at t+1.
REQ-024 Lanes 0-3 all addr=4, data=1, held valid, mem=0 -> grants in order 0,1,2,3 on consecutive cycles; final bank0 addr1 value=4 (forwarding proven).
REQ-025 Lanes 0-3 addr=0,1,2,3 data=7 -> all four req_ready high in one cycle; four writes of 7 in the next cycle.
REQ-026 ACCUM_SAT_EN on, mem=32767, data=5 -> write 32767; macro off -> write -32764.
REQ-027 Reset asserted in the cycle after a grant -> no bank_wr_en; afterwards the pointer is 0 and idle=1.
REQ-028 Lanes 1 and 3 contend for bank2 for 6 cycles -> grants alternate 1,3,1,3,1,3 (no starvation).
